controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 127 ++++++++++++
 tb/tb_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Game controller FSM for the memory/sequence game datapath.
//
// Sequences the datapath through setup, FPGA sequence playback, player entry,
// result checking, an inter-round gap and the result screen. All outputs are
// a Moore decode of the registered state (plus the gap counter in NEXT).
//
// Ports:
//   CLOCK_50  - system clock, rising-edge active
//   reset     - synchronous active-high reset
//   ENTER     - synchronized player confirm button (level)
//   end_FPGA  - datapath: FPGA sequence playback finished
//   end_User  - datapath: player finished entering the sequence
//   end_time  - datapath: player entry timer expired
//   win       - datapath: final round completed
//   match     - datapath: player sequence matches
//   R1, R2    - game reset, round reset
//   E1..E4    - setup, play/timer, FPGA-sequence, round-increment enables
//   SEL       - display select (1 = result screen)
//   state     - current state code
module controller #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ENTER,
    input  logic       end_FPGA,
    input  logic       end_User,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       R1,
    output logic       R2,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       SEL,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StInit     = 3'd0,
        StSetup    = 3'd1,
        StSequence = 3'd2,
        StPlay     = 3'd3,
        StCheck    = 3'd4,
        StNext     = 3'd5,
        StResult   = 3'd6
    } state_e;

    localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic       enter_prev_q;
    logic       enter_edge;

    // Prev resets to 1 so a button held through reset cannot fire an edge.
    assign enter_edge = ENTER & ~enter_prev_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= StInit;
            gap_q        <= 4'd0;
            enter_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            enter_prev_q <= ENTER;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:     state_d = StSetup;
            StSetup:    if (enter_edge) state_d = StSequence;
            StSequence: if (end_FPGA) state_d = StPlay;
            StPlay: begin
                // end_User has priority over a simultaneous timeout
                if (end_User)      state_d = StCheck;
                else if (end_time) state_d = StResult;
            end
            StCheck:    state_d = (match && !win) ? StNext : StResult;
            StNext:     if (gap_q == GapLast) state_d = StSequence;
            StResult:   if (enter_edge) state_d = StInit;
            default:    state_d = StInit;
        endcase
    end

    // Gap counter is zero on NEXT entry and counts cycles spent in NEXT.
    always_comb begin
        gap_d = 4'd0;
        if (state_q == StNext && state_d == StNext) begin
            gap_d = gap_q + 4'd1;
        end
    end

    // Moore output decode
    always_comb begin
        R1    = 1'b0;
        R2    = 1'b0;
        E1    = 1'b0;
        E2    = 1'b0;
        E3    = 1'b0;
        E4    = 1'b0;
        SEL   = 1'b0;
        state = state_q;
        case (state_q)
            StInit: begin
                R1 = 1'b1;
                R2 = 1'b1;
            end
            StSetup:    E1 = 1'b1;
            StSequence: E3 = 1'b1;
            StPlay:     E2 = 1'b1;
            StNext: begin
                R2 = 1'b1;
                E4 = (gap_q == 4'd0);
            end
            StResult:   SEL = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: directed vector table, a NEXT-window sequence and
// randomized stimulus compared against a cycle-level reference model.
module tb_controller;

    localparam int unsigned GAP = 4;

    logic       clk;
    logic       reset, enter, end_fpga, end_user, end_time, win, match;
    logic       r1, r2, e1, e2, e3, e4, sel;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    controller #(.GAP_CYCLES(GAP)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .ENTER    (enter),
        .end_FPGA (end_fpga),
        .end_User (end_user),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (r1),
        .R2       (r2),
        .E1       (e1),
        .E2       (e2),
        .E3       (e3),
        .E4       (e4),
        .SEL      (sel),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector layout: {R1,R2,E1,E2,E3,E4,SEL,state[2:0]}
    localparam logic [9:0] O_INIT  = {7'b1100000, 3'd0};
    localparam logic [9:0] O_SETUP = {7'b0010000, 3'd1};
    localparam logic [9:0] O_SEQ   = {7'b0000100, 3'd2};
    localparam logic [9:0] O_PLAY  = {7'b0001000, 3'd3};
    localparam logic [9:0] O_CHK   = {7'b0000000, 3'd4};
    localparam logic [9:0] O_NX1   = {7'b0100010, 3'd5};
    localparam logic [9:0] O_NXN   = {7'b0100000, 3'd5};
    localparam logic [9:0] O_RES   = {7'b0000001, 3'd6};

    function automatic logic [9:0] dut_out();
        return {r1, r2, e1, e2, e3, e4, sel, state};
    endfunction

    // ---------------- reference model ----------------
    int m_state;   // state code
    bit m_prev;    // last sampled ENTER
    int m_left;    // NEXT cycles remaining, including the current one

    function automatic void model_step(bit rst, bit en, bit ef, bit eu, bit et, bit w, bit m);
        bit rise;
        if (rst) begin
            m_state = 0;
            m_prev  = 1'b1;
            m_left  = 0;
            return;
        end
        rise   = en && !m_prev;
        m_prev = en;
        case (m_state)
            0: m_state = 1;
            1: if (rise) m_state = 2;
            2: if (ef) m_state = 3;
            3: if (eu) m_state = 4; else if (et) m_state = 6;
            4: if (m && !w) begin m_state = 5; m_left = GAP; end else m_state = 6;
            5: begin
                m_left = m_left - 1;
                if (m_left == 0) m_state = 2;
            end
            6: if (rise) m_state = 0;
            default: m_state = 0;
        endcase
    endfunction

    function automatic logic [9:0] model_out();
        logic [9:0] o;
        case (m_state)
            0: o = O_INIT;
            1: o = O_SETUP;
            2: o = O_SEQ;
            3: o = O_PLAY;
            4: o = O_CHK;
            5: o = (m_left == GAP) ? O_NX1 : O_NXN;
            6: o = O_RES;
            default: o = 10'h3ff;
        endcase
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic check_vec(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Apply inputs for one clock, advance the model, sample #1 after the edge.
    task automatic cyc(input bit rst, input bit en, input bit ef, input bit eu,
                       input bit et, input bit w, input bit m);
        reset    = rst;
        enter    = en;
        end_fpga = ef;
        end_user = eu;
        end_time = et;
        win      = w;
        match    = m;
        @(posedge clk);
        model_step(rst, en, ef, eu, et, w, m);
        #1;
    endtask

    typedef struct packed {
        logic       rst, en, ef, eu, et, w, m;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit en, input bit ef, input bit eu,
                       input bit et, input bit w, input bit m, input logic [9:0] e);
        vecs.push_back('{rst, en, ef, eu, et, w, m, e});
    endtask

    initial begin
        int r2_cnt, e4_cnt;
        bit found;
        bit en_r;

        reset = 1'b1; enter = 1'b0; end_fpga = 1'b0; end_user = 1'b0;
        end_time = 1'b0; win = 1'b0; match = 1'b0;
        m_state = 0; m_prev = 1'b1; m_left = 0;

        //  rst en ef eu et w  m   expected
        add(1, 0, 0, 0, 0, 0, 0, O_INIT);   // reset 2 cycles
        add(1, 0, 0, 0, 0, 0, 0, O_INIT);
        add(0, 0, 0, 0, 0, 0, 0, O_SETUP);  // INIT -> SETUP unconditionally
        add(0, 0, 1, 1, 1, 1, 1, O_SETUP);  // status flags ignored in SETUP
        add(0, 1, 0, 0, 0, 0, 0, O_SEQ);    // ENTER rise
        add(0, 0, 0, 1, 1, 0, 0, O_SEQ);    // waits for end_FPGA
        add(0, 0, 1, 0, 0, 0, 0, O_PLAY);
        add(0, 0, 0, 1, 0, 0, 1, O_CHK);    // end_User
        add(0, 0, 0, 0, 0, 0, 1, O_NX1);    // match, !win -> NEXT, E4 first cycle
        add(0, 0, 0, 0, 0, 0, 0, O_NXN);
        add(0, 1, 1, 1, 1, 1, 1, O_NXN);    // inputs ignored in NEXT
        add(0, 0, 0, 0, 0, 0, 0, O_NXN);
        add(0, 0, 0, 0, 0, 0, 0, O_SEQ);    // 4 NEXT cycles then SEQUENCE
        add(0, 0, 1, 0, 0, 0, 0, O_PLAY);
        add(0, 0, 0, 0, 1, 0, 0, O_RES);    // timeout
        add(0, 1, 0, 0, 0, 0, 0, O_INIT);   // ENTER rise leaves RESULT
        add(0, 0, 0, 0, 0, 0, 0, O_SETUP);
        add(0, 1, 0, 0, 0, 0, 0, O_SEQ);
        add(0, 0, 1, 0, 0, 0, 0, O_PLAY);
        add(0, 0, 0, 1, 1, 1, 1, O_CHK);    // simultaneous end_User/end_time
        add(0, 0, 0, 0, 0, 1, 1, O_RES);    // match & win
        add(0, 0, 0, 0, 0, 0, 0, O_RES);
        add(0, 1, 0, 0, 0, 0, 0, O_INIT);
        add(0, 0, 0, 0, 0, 0, 0, O_SETUP);
        add(0, 1, 0, 0, 0, 0, 0, O_SEQ);
        add(0, 0, 1, 0, 0, 0, 0, O_PLAY);
        add(0, 1, 0, 1, 0, 0, 0, O_CHK);    // ENTER ignored in PLAY
        add(0, 0, 0, 0, 0, 1, 0, O_RES);    // match=0 -> RESULT
        add(0, 1, 0, 0, 0, 0, 0, O_INIT);   // held ENTER: one return only
        for (int i = 0; i < 9; i++) add(0, 1, 0, 0, 0, 0, 0, O_SETUP);
        add(0, 0, 0, 0, 0, 0, 0, O_SETUP);
        add(0, 1, 0, 0, 0, 0, 0, O_SEQ);
        add(0, 1, 1, 0, 0, 0, 0, O_PLAY);
        add(0, 1, 0, 1, 0, 0, 1, O_CHK);
        add(0, 1, 0, 0, 0, 0, 1, O_NX1);
        add(0, 1, 0, 0, 0, 0, 0, O_NXN);    // 2nd NEXT cycle
        add(1, 1, 0, 0, 0, 0, 0, O_INIT);   // reset aborts NEXT
        add(1, 1, 0, 0, 0, 0, 0, O_INIT);   // reset held with ENTER high
        add(0, 1, 0, 0, 0, 0, 0, O_SETUP);
        add(0, 1, 0, 0, 0, 0, 0, O_SETUP);  // still held: no advance
        add(0, 0, 0, 0, 0, 0, 0, O_SETUP);
        add(0, 1, 0, 0, 0, 0, 0, O_SEQ);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].en, vecs[i].ef, vecs[i].eu,
                vecs[i].et, vecs[i].w, vecs[i].m);
            check_vec($sformatf("vec[%0d]", i), dut_out(), vecs[i].exp);
        end

        // NEXT window: count R2 and E4 cycles until SEQUENCE returns.
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check_vec("seq_check", dut_out(), O_CHK);
        r2_cnt = 0; e4_cnt = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            if (state == 3'd5) begin
                r2_cnt += int'(r2);
                e4_cnt += int'(e4);
            end
            if (state == 3'd2) found = 1'b1;
        end
        check_int("next_exit_seen", int'(found), 1);
        check_int("next_r2_cycles", r2_cnt, GAP);
        check_int("next_e4_pulses", e4_cnt, 1);

        // Randomized run against the model.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check_vec("rand_reset", dut_out(), O_INIT);
        en_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) en_r = ~en_r;
            cyc($urandom_range(0, 79) == 0, en_r,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) != 0);
            check_vec($sformatf("rand[%0d]", i), dut_out(), model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
